// File: rtl/rs232out.sv
// rs232out: 8N1 UART transmitter fed by a small byte FIFO.
// Define RS232OUT_PARITY_EN to insert an even parity bit (8E1 frame).
module rs232out #(
  parameter int bps       = 57_600,
  parameter int frequency = 25_000_000,
  parameter int period    = (frequency + bps / 2) / bps,
  parameter int fifo_log2 = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] transmit_data,
  input  logic       write,
  output logic       busy,
  output logic       idle,
  output logic       serial_out
);

  localparam int depth = 2 ** fifo_log2;
  localparam int tw = $clog2(period);
  localparam logic [tw-1:0] reload = tw'(period - 1);
  localparam logic [fifo_log2:0] full = (fifo_log2 + 1)'(depth);

`ifdef RS232OUT_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t state, state_n;

  logic [7:0]           mem [depth];
  logic [fifo_log2-1:0] rd_ptr, wr_ptr;
  logic [fifo_log2:0]   count, count_n;
  logic                 has_data;

  logic [tw-1:0] timer, timer_n;
  logic [2:0]    bits, bits_n;
  logic [7:0]    shift, shift_n;
  logic          tx, tx_n;
  logic          tick, ready, launch;
  logic          push, pop;
`ifdef RS232OUT_PARITY_EN
  logic          par, par_n;
`endif

  // has_data lags count by one cycle, giving the two-edge write-to-start latency
  assign ready = has_data && (count != '0);
  assign serial_out = tx;

  always_comb begin
    state_n = state;
    timer_n = timer;
    bits_n  = bits;
    shift_n = shift;
    tx_n    = tx;
    pop     = 1'b0;
    launch  = 1'b0;
`ifdef RS232OUT_PARITY_EN
    par_n   = par;
`endif
    tick = (timer == '0);
    if (state != IDLE && !tick) timer_n = timer - 1'b1;
    unique case (state)
      IDLE: launch = ready;
      START: begin
        if (tick) begin
          tx_n    = shift[0];
          shift_n = {1'b0, shift[7:1]};
          bits_n  = 3'd7;
          timer_n = reload;
          state_n = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          timer_n = reload;
          if (bits != 3'd0) begin
            tx_n    = shift[0];
            shift_n = {1'b0, shift[7:1]};
            bits_n  = bits - 1'b1;
          end else begin
`ifdef RS232OUT_PARITY_EN
            tx_n    = par;
            state_n = PARITY;
`else
            tx_n    = 1'b1;
            state_n = STOP;
`endif
          end
        end
      end
`ifdef RS232OUT_PARITY_EN
      PARITY: begin
        if (tick) begin
          tx_n    = 1'b1;
          timer_n = reload;
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (ready) launch = 1'b1;
          else state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (launch) begin
      pop     = 1'b1;
      shift_n = mem[rd_ptr];
      tx_n    = 1'b0;
      timer_n = reload;
      state_n = START;
`ifdef RS232OUT_PARITY_EN
      par_n   = ^mem[rd_ptr];
`endif
    end
    // a pop in the same cycle frees the slot, so a full FIFO may still take a write
    push = write && ((count != full) || pop);
    count_n = count;
    unique case ({push, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= transmit_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      bits     <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      has_data <= 1'b0;
      busy     <= 1'b0;
      idle     <= 1'b1;
`ifdef RS232OUT_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      bits     <= bits_n;
      shift    <= shift_n;
      tx       <= tx_n;
      count    <= count_n;
      has_data <= (count != '0);
      busy     <= (count_n == full);
      idle     <= (state_n == IDLE) && (count_n == '0);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
`ifdef RS232OUT_PARITY_EN
      par      <= par_n;
`endif
    end
  end

endmodule
